// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE,
      SHIFT,
      FIN
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell, gate level: D = A^B^BIN, BO = ~A&B | ~(A^B)&BIN.
module full_subtractor (
   output logic D,
   output logic BO,
   input  logic A,
   input  logic B,
   input  logic BIN
);

   logic axb;
   logic na;
   logic nxb;
   logic t_ab;
   logic t_bin;

   xor g_x1 (axb, A, B);
   xor g_x2 (D, axb, BIN);
   not g_n1 (na, A);
   and g_a1 (t_ab, na, B);
   not g_n2 (nxb, axb);
   and g_a2 (t_bin, nxb, BIN);
   or  g_o1 (BO, t_ab, t_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell with a registered borrow.
// Result registers update once per operation and hold until the next one completes.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] DIFF,
   output logic             BOUT,
   output logic             VOUT,
   output logic             BUSY,
   output logic             DONE
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_nxt;
   logic             borrow;
   logic             bmsb;
   logic [CW-1:0]    count;
   logic             last;
   logic             d;
   logic             bo;

   full_subtractor u_cell (
      .D   (d),
      .BO  (bo),
      .A   (sa[0]),
      .B   (sb[0]),
      .BIN (borrow)
   );

   assign last   = (count == CW'(WIDTH - 1));
   assign sr_nxt = {d, sr[WIDTH-1:1]};

   // Overflow is borrow-into-MSB xor borrow-out; both are latched on the MSB edge,
   // so deriving it from the two registers keeps it stable between operations.
   assign VOUT = BOUT ^ bmsb;

   // State register; reset takes priority over any request.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and status strobes.
   always_comb begin
      state_nxt = state;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      case (state)
         IDLE:  if (START) state_nxt = SHIFT;
         SHIFT: begin
            BUSY = 1'b1;
            if (last) state_nxt = FIN;
         end
         FIN: begin
            DONE      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, serial datapath and result registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sa     <= '0;
         sb     <= '0;
         sr     <= '0;
         borrow <= 1'b0;
         bmsb   <= 1'b0;
         count  <= '0;
         DIFF   <= '0;
         BOUT   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  sa     <= A;
                  sb     <= B;
                  sr     <= '0;
                  borrow <= 1'b0;
                  count  <= '0;
               end
            end
            SHIFT: begin
               sr     <= sr_nxt;
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               borrow <= bo;
               count  <= count + CW'(1);
               if (last) begin
                  bmsb <= borrow;
                  DIFF <= sr_nxt;
                  BOUT <= bo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vector table plus corner
// sequences, and an exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_subtractor;

   logic       CLK = 1'b0;
   logic       RST;
   logic       START;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] DIFF;
   logic       BOUT;
   logic       VOUT;
   logic       BUSY;
   logic       DONE;

   logic       START4;
   logic [3:0] A4;
   logic [3:0] B4;
   logic [3:0] DIFF4;
   logic       BOUT4;
   logic       VOUT4;
   logic       BUSY4;
   logic       DONE4;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       bout;
      logic       vout;
   } vec_t;

   vec_t vecs [7];

   always #5 CLK = ~CLK;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .A     (A),
      .B     (B),
      .DIFF  (DIFF),
      .BOUT  (BOUT),
      .VOUT  (VOUT),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .CLK   (CLK),
      .RST   (RST),
      .START (START4),
      .A     (A4),
      .B     (B4),
      .DIFF  (DIFF4),
      .BOUT  (BOUT4),
      .VOUT  (VOUT4),
      .BUSY  (BUSY4),
      .DONE  (DONE4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // One full WIDTH=8 operation: load, scramble inputs, time BUSY/DONE, check result.
   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d, input logic bo, input logic vo);
      int unsigned lat;
      int unsigned busy_cnt;
      logic        got;
      logic        overlap;
      @(negedge CLK);
      START = 1'b1; A = a; B = b;
      @(negedge CLK);
      START = 1'b0; A = ~a; B = ~b;
      lat = 0; busy_cnt = 0; got = 1'b0; overlap = 1'b0;
      while (!got && lat < 30) begin
         if (BUSY && DONE) overlap = 1'b1;
         if (DONE) got = 1'b1;
         else begin
            if (BUSY) busy_cnt++;
            lat++;
            @(negedge CLK);
         end
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, lat, 32'd8);
      chk({tag, "_busy_cycles"}, busy_cnt, 32'd8);
      chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
      chk({tag, "_diff"}, 32'(DIFF), 32'(d));
      chk({tag, "_bout"}, 32'(BOUT), 32'(bo));
      chk({tag, "_vout"}, 32'(VOUT), 32'(vo));
      @(negedge CLK);
      chk({tag, "_done_one_cycle"}, 32'(DONE), 32'd0);
      chk({tag, "_idle_not_busy"}, 32'(BUSY), 32'd0);
   endtask

   // One WIDTH=4 operation compared against an arithmetic reference.
   task automatic run4(input int a, input int b);
      int unsigned lat;
      logic        got;
      int          sa;
      int          sb;
      int          r;
      string       tag;
      tag = $sformatf("w4_%0d_%0d", a, b);
      @(negedge CLK);
      START4 = 1'b1; A4 = 4'(a); B4 = 4'(b);
      @(negedge CLK);
      START4 = 1'b0; A4 = ~A4; B4 = ~B4;
      lat = 0; got = 1'b0;
      while (!got && lat < 20) begin
         if (DONE4) got = 1'b1;
         else begin
            lat++;
            @(negedge CLK);
         end
      end
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      r  = sa - sb;
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, lat, 32'd4);
      chk({tag, "_diff"}, 32'(DIFF4), 32'((a - b) & 15));
      chk({tag, "_bout"}, 32'(BOUT4), 32'(a < b));
      chk({tag, "_vout"}, 32'(VOUT4), 32'((r > 7) || (r < -8)));
      @(negedge CLK);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned n_done;
      int unsigned lat_first;
      logic [7:0]  diff_first;

      vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
      vecs[5] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
      vecs[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

      RST = 1'b1; START = 1'b0; A = '0; B = '0;
      START4 = 1'b0; A4 = '0; B4 = '0;
      repeat (2) @(negedge CLK);
      chk("reset_diff", 32'(DIFF), 32'd0);
      chk("reset_bout", 32'(BOUT), 32'd0);
      chk("reset_vout", 32'(VOUT), 32'd0);
      chk("reset_busy", 32'(BUSY), 32'd0);
      chk("reset_done", 32'(DONE), 32'd0);
      RST = 1'b0;

      for (int unsigned i = 0; i < 7; i++)
         run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff,
              vecs[i].bout, vecs[i].vout);

      // Reset four cycles into SHIFT: prior result (0x80,1,1) must be cleared.
      @(negedge CLK);
      START = 1'b1; A = 8'h11; B = 8'h22;
      @(negedge CLK);
      START = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("midrst_busy", 32'(BUSY), 32'd0);
      chk("midrst_done", 32'(DONE), 32'd0);
      chk("midrst_diff", 32'(DIFF), 32'd0);
      chk("midrst_bout", 32'(BOUT), 32'd0);
      chk("midrst_vout", 32'(VOUT), 32'd0);
      n_done = 0;
      for (int s = 0; s < 12; s++) begin
         if (DONE) n_done++;
         @(negedge CLK);
      end
      chk("midrst_no_done", n_done, 32'd0);
      run8("after_rst", 8'hC8, 8'h64, 8'h64, 1'b0, 1'b1);

      // RST and START together: the request is dropped.
      @(negedge CLK);
      RST = 1'b1; START = 1'b1; A = 8'h09; B = 8'h04;
      @(negedge CLK);
      RST = 1'b0; START = 1'b0;
      chk("rst_start_busy0", 32'(BUSY), 32'd0);
      @(negedge CLK);
      chk("rst_start_busy1", 32'(BUSY), 32'd0);

      // START re-pulsed mid-operation with new operands must be ignored.
      @(negedge CLK);
      START = 1'b1; A = 8'h5A; B = 8'h21;
      @(negedge CLK);
      START = 1'b0; A = 8'h00; B = 8'h00;
      n_done = 0; lat_first = 99; diff_first = '0;
      for (int s = 0; s < 25; s++) begin
         if (DONE) begin
            n_done++;
            if (n_done == 1) begin
               lat_first  = s;
               diff_first = DIFF;
            end
         end
         if (s == 3) begin
            START = 1'b1; A = 8'hFF; B = 8'h00;
         end else begin
            START = 1'b0;
         end
         @(negedge CLK);
      end
      chk("ignore_start_ndone", n_done, 32'd1);
      chk("ignore_start_latency", lat_first, 32'd8);
      chk("ignore_start_diff", 32'(diff_first), 32'h39);
      chk("ignore_start_hold", 32'(DIFF), 32'h39);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run4(a, b);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
